cia_irq_sequencer: RTL and testbench

Sequences the five CIA interrupt sources into the interrupt register logic. It derives one-clock phase strobes (phi2 up/down, phi1 step 1/2) from the synchronized PHI2 level, and synchronizes and edge-detects the FLAG pin. It holds single-clock event strobes from the timers, TOD and serial port pending until the next phi2 falling edge, then presents them as a `sources` vector that is stable for a whole phi2 cycle. It also flags loss of the PHI2 clock.

---
 rtl/cia_irq_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_cia_irq_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cia_irq_sequencer.sv
// cia_irq_sequencer
// Collects the five CIA interrupt sources (timer A, timer B, TOD alarm,
// serial port, FLAG pin) and presents them to the interrupt register as a
// vector that is stable for one full phi2 cycle. It also produces the phi2
// phase strobes and flags a stalled PHI2 clock.
//
// Build option: define CIA_FLAG_FILTER_EN to require the synchronized FLAG
// to stay low for 4 clocks before a fall is accepted. Without it a single
// synchronized falling sample is enough.

module cia_irq_sequencer #(
  parameter int PHI2_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       phi2_in,
  input  logic       flag_n,
  input  logic       ev_ta,
  input  logic       ev_tb,
  input  logic       ev_alrm,
  input  logic       ev_sp,
  output logic       phi2_up,
  output logic       phi2_dn,
  output logic       phi1_s1,
  output logic       phi1_s2,
  output logic [4:0] sources,
  output logic [4:0] ev_ovr,
  output logic       phi2_lost
);

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_S1   = 2'd1,
    PH_S2   = 2'd2
  } phase_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(PHI2_TIMEOUT);

  phase_t      phase_q;
  phase_t      phase_d;
  logic        phi2_q;
  logic        flag_s1;
  logic        flag_s2;
  logic        ev_flg;
  logic [4:0]  ev;
  logic [4:0]  pending;
  logic [15:0] to_cnt;
  logic        phi2_edge;
  logic        capture;
  logic        to_hit;

  // PHI2 level history and registered one-clock edge strobes
  always_ff @(posedge clk) begin
    phi2_q <= phi2_in;
    if (!res_n) begin
      phi2_dn <= 1'b0;
      phi2_up <= 1'b0;
    end else begin
      phi2_dn <= phi2_q & ~phi2_in;
      phi2_up <= ~phi2_q & phi2_in;
    end
  end

  // Phase state register
  always_ff @(posedge clk) begin
    if (!res_n) begin
      phase_q <= PH_IDLE;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase sequencing IDLE -> S1 -> S2 -> IDLE; a new phi2 fall restarts at S1
  always_comb begin
    phase_d = phase_q;
    phi1_s1 = 1'b0;
    phi1_s2 = 1'b0;
    case (phase_q)
      PH_IDLE: phase_d = PH_IDLE;
      PH_S1: begin
        phi1_s1 = 1'b1;
        phase_d = PH_S2;
      end
      PH_S2: begin
        phi1_s2 = 1'b1;
        phase_d = PH_IDLE;
      end
      default: phase_d = PH_IDLE;
    endcase
    if (phi2_dn) begin
      phase_d = PH_S1;
    end
  end

  // Two-flop synchronizer for the asynchronous FLAG pin (idles high)
  always_ff @(posedge clk) begin
    if (!res_n) begin
      flag_s1 <= 1'b1;
      flag_s2 <= 1'b1;
    end else begin
      flag_s1 <= flag_n;
      flag_s2 <= flag_s1;
    end
  end

`ifdef CIA_FLAG_FILTER_EN
  logic       flag_armed;
  logic [1:0] flag_low_cnt;

  // Accept a FLAG fall only after 4 consecutive low samples following a high
  always_ff @(posedge clk) begin
    if (!res_n) begin
      flag_armed   <= 1'b1;
      flag_low_cnt <= 2'd0;
      ev_flg       <= 1'b0;
    end else begin
      ev_flg <= 1'b0;
      if (flag_s2) begin
        flag_armed   <= 1'b1;
        flag_low_cnt <= 2'd0;
      end else if (flag_armed) begin
        if (flag_low_cnt == 2'd3) begin
          ev_flg       <= 1'b1;
          flag_armed   <= 1'b0;
          flag_low_cnt <= 2'd0;
        end else begin
          flag_low_cnt <= flag_low_cnt + 2'd1;
        end
      end
    end
  end
`else
  logic flag_prev;

  // Single-sample falling-edge detect on the synchronized FLAG
  always_ff @(posedge clk) begin
    if (!res_n) begin
      flag_prev <= 1'b1;
      ev_flg    <= 1'b0;
    end else begin
      flag_prev <= flag_s2;
      ev_flg    <= flag_prev & ~flag_s2;
    end
  end
`endif

  assign ev        = {ev_flg, ev_sp, ev_alrm, ev_tb, ev_ta};
  assign capture   = phi2_dn;
  assign phi2_edge = phi2_up | phi2_dn;
  assign to_hit    = ~phi2_edge & (to_cnt == TIMEOUT_CNT);

  // Hold events until the next capture; a repeat before capture is an overrun
  always_ff @(posedge clk) begin
    if (!res_n) begin
      pending <= 5'b0;
      ev_ovr  <= 5'b0;
    end else if (capture) begin
      pending <= 5'b0;
    end else begin
      pending <= pending | ev;
      ev_ovr  <= ev_ovr | (ev & pending);
    end
  end

  // Present captured sources for a whole phi2 cycle; blank them on PHI2 loss
  always_ff @(posedge clk) begin
    if (!res_n) begin
      sources <= 5'b0;
    end else if (capture) begin
      sources <= pending | ev;
    end else if (to_hit) begin
      sources <= 5'b0;
    end
  end

  // PHI2 watchdog: saturating count of clocks since the last edge strobe
  always_ff @(posedge clk) begin
    if (!res_n) begin
      to_cnt    <= 16'd0;
      phi2_lost <= 1'b0;
    end else begin
      if (phi2_edge) begin
        to_cnt <= 16'd0;
      end else if (to_cnt != 16'hFFFF) begin
        to_cnt <= to_cnt + 16'd1;
      end
      if (phi2_edge) begin
        phi2_lost <= 1'b0;
      end else if (to_hit) begin
        phi2_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cia_irq_sequencer.sv
// Testbench for cia_irq_sequencer: directed PHI2/event sequences, expected
// capture values pushed into a scoreboard and checked by a separate monitor.

module tb_cia_irq_sequencer;

  localparam int TO = 24;

  localparam logic [3:0] EV_TA   = 4'b0001;
  localparam logic [3:0] EV_TB   = 4'b0010;
  localparam logic [3:0] EV_ALRM = 4'b0100;
  localparam logic [3:0] EV_SP   = 4'b1000;
  localparam logic [3:0] EV_NONE = 4'b0000;

`ifdef CIA_FLAG_FILTER_EN
  localparam logic [4:0] OVR_FLG = 5'b00000;
`else
  localparam logic [4:0] OVR_FLG = 5'b10000;
`endif

  typedef struct packed {
    logic [4:0] src;
    logic [4:0] ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       res_n;
  logic       phi2_in;
  logic       flag_n;
  logic       ev_ta;
  logic       ev_tb;
  logic       ev_alrm;
  logic       ev_sp;
  logic       phi2_up;
  logic       phi2_dn;
  logic       phi1_s1;
  logic       phi1_s2;
  logic [4:0] sources;
  logic [4:0] ev_ovr;
  logic       phi2_lost;

  int   total = 0;
  int   bad = 0;
  logic started = 1'b0;
  exp_t exp_q[$];

  // monitor history
  logic       p1 = 1'b1;
  logic       p2 = 1'b1;
  logic       r1 = 1'b0;
  logic       edn1 = 1'b0;
  logic       es1_1 = 1'b0;
  logic       lost_prev = 1'b0;
  logic [4:0] held = 5'b0;

  always #5 clk = ~clk;

  cia_irq_sequencer #(.PHI2_TIMEOUT(TO)) dut (
    .clk      (clk),
    .res_n    (res_n),
    .phi2_in  (phi2_in),
    .flag_n   (flag_n),
    .ev_ta    (ev_ta),
    .ev_tb    (ev_tb),
    .ev_alrm  (ev_alrm),
    .ev_sp    (ev_sp),
    .phi2_up  (phi2_up),
    .phi2_dn  (phi2_dn),
    .phi1_s1  (phi1_s1),
    .phi1_s2  (phi1_s2),
    .sources  (sources),
    .ev_ovr   (ev_ovr),
    .phi2_lost(phi2_lost)
  );

  task automatic checkOutput(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushExp(input logic [4:0] src, input logic [4:0] ovr);
    exp_t e;
    e.src = src;
    e.ovr = ovr;
    exp_q.push_back(e);
  endtask

  // drive one clock cycle of inputs; event strobes last exactly this cycle
  task automatic applyStimulus(input logic phi2, input logic [3:0] ev, input logic flag);
    phi2_in = phi2;
    {ev_sp, ev_alrm, ev_tb, ev_ta} = ev;
    flag_n = flag;
    @(posedge clk);
    #1;
    {ev_sp, ev_alrm, ev_tb, ev_ta} = 4'b0;
  endtask

  task automatic halfCycle(input logic level, input int n,
                           input int ia, input logic [3:0] ea,
                           input int ib, input logic [3:0] eb,
                           input int ic, input logic [3:0] ec);
    logic [3:0] ev;
    for (int i = 0; i < n; i++) begin
      ev = 4'b0;
      if (i == ia) ev = ev | ea;
      if (i == ib) ev = ev | eb;
      if (i == ic) ev = ev | ec;
      applyStimulus(level, ev, 1'b1);
    end
  endtask

  // monitor: strobe timing from the driven PHI2, scoreboard pop on phi1_s1
  always @(negedge clk) begin : monitor
    logic exp_dn;
    logic exp_up;
    logic exp_s1;
    logic exp_s2;
    exp_t e;
    exp_dn = r1 & p2 & ~p1;
    exp_up = r1 & ~p2 & p1;
    exp_s1 = r1 & edn1;
    exp_s2 = r1 & es1_1 & ~edn1;
    if (started) begin
      checkOutput("phi2_dn", 5'(phi2_dn), 5'(exp_dn));
      checkOutput("phi2_up", 5'(phi2_up), 5'(exp_up));
      checkOutput("phi1_s1", 5'(phi1_s1), 5'(exp_s1));
      checkOutput("phi1_s2", 5'(phi1_s2), 5'(exp_s2));
      if (res_n) begin
        if (phi2_lost && !lost_prev) held = 5'b0;
        if (phi1_s1) begin
          if (exp_q.size() == 0) begin
            checkOutput("scoreboard_underflow", 5'd1, 5'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("capture_sources", sources, e.src);
            checkOutput("capture_ev_ovr", ev_ovr, e.ovr);
            held = e.src;
          end
        end else begin
          checkOutput("sources_hold", sources, held);
        end
      end else begin
        held = 5'b0;
      end
    end
    lost_prev = phi2_lost;
    p2 = p1;
    p1 = phi2_in;
    r1 = res_n;
    edn1 = exp_dn;
    es1_1 = exp_s1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    res_n = 1'b0;
    phi2_in = 1'b1;
    flag_n = 1'b1;
    {ev_sp, ev_alrm, ev_tb, ev_ta} = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    started = 1'b1;
    checkOutput("reset_sources", sources, 5'b0);
    checkOutput("reset_ev_ovr", ev_ovr, 5'b0);
    checkOutput("reset_lost", 5'(phi2_lost), 5'd0);

    // idle with PHI2 high: no strobes
    res_n = 1'b1;
    halfCycle(1'b1, 10, -1, EV_NONE, -1, EV_NONE, -1, EV_NONE);
    checkOutput("idle_sources", sources, 5'b0);
    checkOutput("idle_lost", 5'(phi2_lost), 5'd0);

    // 20-clk periods, timer A pulsed mid-high
    pushExp(5'b00000, 5'b00000);
    halfCycle(1'b0, 10, -1, EV_NONE, -1, EV_NONE, -1, EV_NONE);
    halfCycle(1'b1, 10, 5, EV_TA, -1, EV_NONE, -1, EV_NONE);
    pushExp(5'b00001, 5'b00000);
    halfCycle(1'b0, 10, -1, EV_NONE, -1, EV_NONE, -1, EV_NONE);
    checkOutput("ta_mid_period", sources, 5'b00001);
    halfCycle(1'b1, 10, -1, EV_NONE, -1, EV_NONE, -1, EV_NONE);
    pushExp(5'b00000, 5'b00000);
    halfCycle(1'b0, 10, -1, EV_NONE, -1, EV_NONE, -1, EV_NONE);

    // timer B pending plus again in the capture cycle; serial port twice
    halfCycle(1'b1, 10, 8, EV_TB, -1, EV_NONE, -1, EV_NONE);
    pushExp(5'b00010, 5'b00000);
    halfCycle(1'b0, 10, 1, EV_TB, 4, EV_SP, 7, EV_SP);
    halfCycle(1'b1, 10, -1, EV_NONE, -1, EV_NONE, -1, EV_NONE);
    pushExp(5'b01000, 5'b01000);
    halfCycle(1'b0, 10, -1, EV_NONE, -1, EV_NONE, -1, EV_NONE);

    // FLAG: 2-clk glitch, 3 high, 8 low, all inside one phi2-high half
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, EV_NONE, !((i < 2) || (i >= 5 && i <= 12)));
    end
    pushExp(5'b10000, 5'b01000 | OVR_FLG);
    halfCycle(1'b0, 10, -1, EV_NONE, -1, EV_NONE, -1, EV_NONE);

    // PHI2 stops low after capturing the alarm
    halfCycle(1'b1, 10, 3, EV_ALRM, -1, EV_NONE, -1, EV_NONE);
    pushExp(5'b00100, 5'b01000 | OVR_FLG);
    halfCycle(1'b0, 26, -1, EV_NONE, -1, EV_NONE, -1, EV_NONE);
    checkOutput("pre_timeout_lost", 5'(phi2_lost), 5'd0);
    checkOutput("pre_timeout_sources", sources, 5'b00100);
    applyStimulus(1'b0, EV_NONE, 1'b1);
    checkOutput("timeout_lost", 5'(phi2_lost), 5'd1);
    checkOutput("timeout_sources", sources, 5'b00000);
    applyStimulus(1'b0, EV_TB, 1'b1);
    applyStimulus(1'b0, EV_NONE, 1'b1);
    applyStimulus(1'b0, EV_NONE, 1'b1);
    applyStimulus(1'b1, EV_NONE, 1'b1);
    checkOutput("lost_at_up_strobe", 5'(phi2_lost), 5'd1);
    applyStimulus(1'b1, EV_NONE, 1'b1);
    checkOutput("lost_cleared", 5'(phi2_lost), 5'd0);
    halfCycle(1'b1, 8, -1, EV_NONE, -1, EV_NONE, -1, EV_NONE);
    pushExp(5'b00010, 5'b01000 | OVR_FLG);
    halfCycle(1'b0, 10, -1, EV_NONE, -1, EV_NONE, -1, EV_NONE);

    // reset while FLAG, TB, TA pending and overrun flags set
    for (int i = 0; i < 14; i++) begin
      res_n = (i != 12);
      if (i == 11) checkOutput("ovr_before_reset", ev_ovr, 5'b01000 | OVR_FLG);
      applyStimulus(1'b1, (i == 2) ? EV_TA : ((i == 3) ? EV_TB : EV_NONE), (i >= 6));
    end
    res_n = 1'b1;
    checkOutput("mid_reset_sources", sources, 5'b0);
    checkOutput("mid_reset_ev_ovr", ev_ovr, 5'b0);
    checkOutput("mid_reset_lost", 5'(phi2_lost), 5'd0);
    pushExp(5'b00000, 5'b00000);
    halfCycle(1'b0, 10, -1, EV_NONE, -1, EV_NONE, -1, EV_NONE);
    halfCycle(1'b1, 10, -1, EV_NONE, -1, EV_NONE, -1, EV_NONE);

    checkOutput("scoreboard_drained", 5'(exp_q.size()), 5'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
